// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDop;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDop, start, input busy, stall, HI, LO);
    modport slave  (input A, B, MDop, start, output busy, stall, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and pipeline stall.
// state  | meaning
// S_IDLE | ready; accepts MULT/DIV, executes MTHI/MTLO
// S_BUSY | op in flight; counter runs down to the HI/LO commit edge
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi, r_lo, r_hi_t, r_lo_t;
    logic               r_div0;

    logic               w_mul_op, w_div_op, w_mt_op;
    logic               w_accept, w_mt, w_done;
    logic signed [63:0] w_a_s, w_b_s, w_bd_s, w_prod_s, w_quot_s, w_rem_s;
    logic [63:0]        w_a_u, w_b_u, w_bd_u, w_prod_u, w_quot_u, w_rem_u;
    logic [31:0]        w_res_hi, w_res_lo;

    always_comb begin
        w_mul_op = (bus.MDop == 3'd1) || (bus.MDop == 3'd2);
        w_div_op = (bus.MDop == 3'd3) || (bus.MDop == 3'd4);
        w_mt_op  = (bus.MDop == 3'd5) || (bus.MDop == 3'd6);
        w_accept = bus.start && (r_state == S_IDLE) && (w_mul_op || w_div_op);
        w_mt     = bus.start && (r_state == S_IDLE) && w_mt_op;
        w_done   = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));
    end

    // Full 64-bit arithmetic; a zero divisor is swapped for 1 since the result is discarded anyway.
    always_comb begin
        w_a_s    = {{32{bus.A[31]}}, bus.A};
        w_b_s    = {{32{bus.B[31]}}, bus.B};
        w_a_u    = {32'd0, bus.A};
        w_b_u    = {32'd0, bus.B};
        w_bd_s   = (bus.B == 32'd0) ? 64'sd1 : w_b_s;
        w_bd_u   = (bus.B == 32'd0) ? 64'd1 : w_b_u;
        w_prod_s = w_a_s * w_b_s;
        w_prod_u = w_a_u * w_b_u;
        w_quot_s = w_a_s / w_bd_s;
        w_rem_s  = w_a_s % w_bd_s;
        w_quot_u = w_a_u / w_bd_u;
        w_rem_u  = w_a_u % w_bd_u;
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (bus.MDop)
            3'd1:    begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            3'd2:    begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            3'd3:    begin w_res_hi = w_rem_s[31:0];   w_res_lo = w_quot_s[31:0]; end
            3'd4:    begin w_res_hi = w_rem_u[31:0];   w_res_lo = w_quot_u[31:0]; end
            default: begin w_res_hi = 32'd0;           w_res_lo = 32'd0;          end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_done)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (r_state == S_BUSY);
        bus.stall = bus.busy || (bus.start && (w_mul_op || w_div_op || w_mt_op));
        bus.HI    = r_hi;
        bus.LO    = r_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_hi_t <= 32'd0;
            r_lo_t <= 32'd0;
            r_div0 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hi_t <= w_res_hi;
                r_lo_t <= w_res_lo;
                r_cnt  <= w_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                r_div0 <= w_div_op && (bus.B == 32'd0);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done && !r_div0) begin
                r_hi <= r_hi_t;
                r_lo <= r_lo_t;
            end else if (w_mt) begin
                if (bus.MDop == 3'd5) r_hi <= bus.A;
                else                  r_lo <= bus.A;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length queued at issue, checked at completion.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
        longint          sp;
        longint unsigned up, ua, ub;
        int              ia, ib, q, r;
        logic [63:0]     res;
        ia  = a;
        ib  = b;
        ua  = 64'(a);
        ub  = 64'(b);
        res = cur;
        case (op)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); res = sp; end
            3'd2: begin up = ua * ub; res = up; end
            3'd3: if (b != 32'd0) begin q = ia / ib; r = ia % ib; res = {r, q}; end
            3'd4: if (b != 32'd0) begin res = {a % b, a / b}; end
            default: res = cur;
        endcase
        return res;
    endfunction

    // Entry and exit at a falling edge; drives one start cycle.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        logic        exp_stall;
        bus.A = a; bus.B = b; bus.MDop = op; bus.start = 1'b1;
        #1;
        exp_stall = (op >= 3'd1) && (op <= 3'd6);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s idle_before_issue: busy=%b expected 0", name, bus.busy);
        end
        checks++;
        if (bus.stall !== exp_stall) begin
            errors++; $display("FAIL %s stall_on_issue: stall=%b expected %b", name, bus.stall, exp_stall);
        end
        if (op >= 3'd1 && op <= 3'd4) begin
            r = model(op, a, b, {m_hi, m_lo});
            e.hi = r[63:32]; e.lo = r[31:0];
            e.cycles = (op <= 3'd2) ? 5 : 10;
            e.name = name;
            sb.push_back(e);
            m_hi = e.hi; m_lo = e.lo;
        end else if (op == 3'd5) begin
            m_hi = a;
        end else if (op == 3'd6) begin
            m_lo = a;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.MDop = 3'd0;
        if (op >= 3'd1 && op <= 3'd4) begin
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++; $display("FAIL %s busy_after_accept: busy=%b expected 1", name, bus.busy);
            end
        end else begin
            checks++;
            if (bus.busy !== 1'b0 || bus.HI !== m_hi || bus.LO !== m_lo) begin
                errors++;
                $display("FAIL %s move_or_none: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                         name, bus.busy, bus.HI, bus.LO, m_hi, m_lo);
            end
        end
    endtask

    task automatic wait_done(input int prior);
        exp_t e;
        int   n;
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty: got completion, expected a queued op");
        end else begin
            e = sb.pop_front();
            if (n + prior != e.cycles) begin
                errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", e.name, n + prior, e.cycles);
            end
            checks++;
            if (bus.HI !== e.hi || bus.LO !== e.lo) begin
                errors++;
                $display("FAIL %s result: HI=%h LO=%h expected HI=%h LO=%h", e.name, bus.HI, bus.LO, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.A = 32'd0; bus.B = 32'd0; bus.MDop = 3'd0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall=%b HI=%h LO=%h expected all 0",
                     bus.busy, bus.stall, bus.HI, bus.LO);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        issue("mult_neg", 3'd1, 32'h0000_0003, 32'hFFFF_FFFE);
        wait_done(0);
        issue("multu_big", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(0);
    endtask

    task automatic test_div;
        issue("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(0);
        issue("divu_small", 3'd4, 32'h0000_0007, 32'h0000_0002);
        wait_done(0);
    endtask

    task automatic test_divzero;
        issue("mthi", 3'd5, 32'h0000_0011, 32'd0);
        issue("mtlo", 3'd6, 32'h0000_0022, 32'd0);
        issue("divu_zero", 3'd4, 32'h0000_0007, 32'd0);
        wait_done(0);
    endtask

    task automatic test_ignore_while_busy;
        issue("mult_hold", 3'd1, 32'h0000_0003, 32'hFFFF_FFFE);
        bus.A = 32'h0000_0055; bus.MDop = 3'd6; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL ignore_mtlo_stall: stall=%b expected 1", bus.stall);
        end
        @(negedge clk);
        bus.A = 32'h0000_0064; bus.B = 32'h0000_0003; bus.MDop = 3'd3; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL ignore_div_stall: stall=%b expected 1", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.MDop = 3'd0;
        wait_done(2);
    endtask

    task automatic test_none;
        issue("op_none0", 3'd0, 32'hDEAD_BEEF, 32'h1);
        issue("op_none7", 3'd7, 32'hDEAD_BEEF, 32'h1);
    endtask

    task automatic test_reset_mid;
        issue("div_reset", 3'd3, 32'h0000_0064, 32'h0000_0007);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.A = 32'h9; bus.B = 32'h9; bus.MDop = 3'd1; bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b HI=%h LO=%h expected 0 0 0", bus.busy, bus.HI, bus.LO);
        end
        reset = 1'b0; bus.start = 1'b0; bus.MDop = 3'd0;
        void'(sb.pop_back());
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL start_during_reset: busy=%b expected 0", bus.busy);
        end
        issue("mult_after_reset", 3'd1, 32'h0000_0004, 32'h0000_0005);
        wait_done(0);
    endtask

    task automatic test_back_to_back;
        issue("b2b_multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(0);
        issue("b2b_divu", 3'd4, m_lo, 32'h0000_0003);
        wait_done(0);
        issue("b2b_div", 3'd3, m_lo, 32'hFFFF_FFFD);
        wait_done(0);
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : $urandom;
            if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            issue("random_op", op, a, b);
            if (op <= 3'd4) wait_done(0);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_ignore_while_busy();
        test_none();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
